// File: rtl/cuca_pkg.sv
// cuca_pkg: definitions shared between the CPU and its bus peripherals.
//   BITW              default bus / word width
//   RW_READ/RW_WRITE  encoding of the rw command bit
//   ram_state_t       states of the burst RAM controller
package cuca_pkg;

  localparam int BITW = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    STATE_CLEAR       = 2'd0,
    STATE_IDLE        = 2'd1,
    STATE_READ_RESULT = 2'd2,
    STATE_WRITE_DATA  = 2'd3
  } ram_state_t;

endpackage

// File: rtl/ram_array.sv
// ram_array: single-port word storage for ram_burst.
//   clock  rising-edge clock
//   we     write enable; wdata is stored at addr on the edge
//   addr   word address shared by read and write (must be < DEPTH)
//   wdata  write data
//   rdata  registered read data: mem[addr] as seen before the edge
// The array carries no reset; its contents are initialised by the
// controller's clear sweep.
module ram_array #(
  parameter  int BITW   = 8,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BITW-1:0]   wdata,
  output logic [BITW-1:0]   rdata
);

  logic [BITW-1:0] mem_q [DEPTH];
  logic [BITW-1:0] rdata_q;

  // Storage write and synchronous read of the addressed word.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_burst.sv
// ram_burst: burst-capable RAM on the shared CPU data bus.
//   clock      rising-edge clock
//   reset      asynchronous active-high reset; starts the clear sweep
//   enable     command strobe in IDLE, beat strobe during a burst
//   rw         command direction (RW_READ / RW_WRITE), sampled with the command
//   burst_len  beats minus one, sampled with the command
//   bus_in     address on the command cycle, write data on write beats
//   bus_out    read data
//   bus_drive  high while bus_out carries valid read data (tristate enable)
//   busy       high while the memory is being cleared; commands ignored
//   err        one-cycle pulse after a command addressing beyond DEPTH
module ram_burst #(
  parameter  int BITW    = cuca_pkg::BITW,
  parameter  int DEPTH   = 256,
  parameter  int BURST_W = 4,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               rw,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [BITW-1:0]    bus_in,
  output logic [BITW-1:0]    bus_out,
  output logic               bus_drive,
  output logic               busy,
  output logic               err
);

  import cuca_pkg::*;

  if (ADDR_W > BITW) begin : g_addr_w_check
    $error("ram_burst: ADDR_W (%0d) must not exceed BITW (%0d)", ADDR_W, BITW);
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BITW:0]     DEPTH_W   = (BITW + 1)'(DEPTH);

  // Bursts wrap at DEPTH, which need not be a power of two.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    if (a == LAST_ADDR) begin
      return '0;
    end else begin
      return a + ADDR_W'(1);
    end
  endfunction

  ram_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [BURST_W-1:0] count_q, count_d;
  logic               drive_q, drive_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [BITW-1:0]    hold_q, hold_d;

  logic               mem_we_s;
  logic [ADDR_W-1:0]  mem_addr_s;
  logic [BITW-1:0]    mem_wdata_s;
  logic [BITW-1:0]    mem_rdata_s;
  logic               cmd_oor_s;
  logic [ADDR_W-1:0]  cmd_addr_s;

  // The range check uses every bus bit, not only the address slice.
  assign cmd_oor_s  = ({1'b0, bus_in} >= DEPTH_W);
  assign cmd_addr_s = bus_in[ADDR_W-1:0];

  ram_array #(
    .BITW  (BITW),
    .DEPTH (DEPTH)
  ) u_array (
    .clock (clock),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .wdata (mem_wdata_s),
    .rdata (mem_rdata_s)
  );

  // Next-state, array port mux and output next values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    drive_d     = drive_q;
    err_d       = 1'b0;
    hold_d      = hold_q;
    mem_we_s    = 1'b0;
    mem_addr_s  = addr_q;
    mem_wdata_s = bus_in;

    case (state_q)
      STATE_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_addr_s  = ptr_q;
        mem_wdata_s = '0;
        if (ptr_q == LAST_ADDR) begin
          ptr_d   = '0;
          state_d = STATE_IDLE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end

      STATE_IDLE: begin
        // Read the command address speculatively so a read command has
        // its data on the bus one cycle later; out-of-range addresses
        // are steered to a legal word.
        mem_addr_s = cmd_oor_s ? '0 : cmd_addr_s;
        if (enable) begin
          addr_d  = cmd_addr_s;
          count_d = burst_len;
          if (cmd_oor_s) begin
            err_d = 1'b1;
          end else if (rw == RW_READ) begin
            state_d = STATE_READ_RESULT;
            drive_d = 1'b1;
          end else begin
            state_d = STATE_WRITE_DATA;
          end
        end else begin
          state_d = STATE_IDLE;
        end
      end

      STATE_READ_RESULT: begin
        // A stall re-reads the presented word so rdata stays put.
        if (enable) begin
          if (count_q == '0) begin
            state_d = STATE_IDLE;
            drive_d = 1'b0;
            hold_d  = mem_rdata_s;
          end else begin
            count_d    = count_q - BURST_W'(1);
            addr_d     = addr_inc(addr_q);
            mem_addr_s = addr_inc(addr_q);
          end
        end else begin
          mem_addr_s = addr_q;
        end
      end

      STATE_WRITE_DATA: begin
        if (enable) begin
          mem_we_s = 1'b1;
          addr_d   = addr_inc(addr_q);
          if (count_q == '0) begin
            state_d = STATE_IDLE;
          end else begin
            count_d = count_q - BURST_W'(1);
          end
        end else begin
          mem_we_s = 1'b0;
        end
      end

      default: begin
        state_d = STATE_CLEAR;
        ptr_d   = '0;
        drive_d = 1'b0;
      end
    endcase

    busy_d = (state_d == STATE_CLEAR);
  end

  // Controller state and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= STATE_CLEAR;
      addr_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      drive_q <= 1'b0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      drive_q <= drive_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  // While driving, the array's own read register is the data source;
  // otherwise the last delivered word (or zero after reset) is shown.
  assign bus_out   = drive_q ? mem_rdata_s : hold_q;
  assign bus_drive = drive_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
